// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-arbiter FSM encoding, register map
// constants and small elaboration helpers.
package uart_pkg;

    // Transmit arbiter states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } tx_state_e;

    // UART register map
    localparam logic [31:0] UART_TXD_ADDR = 32'h8000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h8000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h8000_0020;

    // Requester identifiers as carried on grant_id and the last-grant pointer
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    // Larger of two counts, used to size the shared gap/timeout counter
    function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Bit 0 is requester A, bit 1 is requester B.
// On a tie the requester that did not win last time is chosen; a lone
// requester always wins regardless of history.
module rr_arb2
    import uart_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant from the request pair and the last-grant pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GNT_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte sources (CPU store path A, receive-echo path B) onto
// a single UART transmitter. One frame at a time: accept a byte, pulse
// tx_start, wait for the transmitter to go busy and then idle again, then
// hold off for GAP_CYC cycles before the next grant. A transmitter that
// never raises tx_busy is abandoned after BUSY_TO cycles with a tx_err pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned BUSY_TO = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       tx_err
);

    // One counter serves both the busy timeout and the inter-frame gap
    localparam int unsigned CNT_MAX = max_u(GAP_CYC, BUSY_TO);
    localparam int          CW      = $clog2(CNT_MAX) + 1;
    // Terminal counts; a zero parameter still spends one cycle in its state
    localparam logic [CW-1:0] BUSY_LAST = (BUSY_TO == 0) ? '0 : CW'(BUSY_TO - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYC == 0) ? '0 : CW'(GAP_CYC - 1);

    tx_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_gnt;
    logic [1:0]    gnt;
    logic          accept;
    logic          err_nxt;

    rr_arb2 u_rr (
        .req  ({b_valid, a_valid}),
        .last (last_gnt),
        .gnt  (gnt)
    );

    // Next-state, counter and launch decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        err_nxt   = 1'b0;
        tx_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A transmitter still busy from elsewhere blocks the grant
                if (!tx_busy && (a_valid || b_valid)) begin
                    accept    = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_start  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (cnt == BUSY_LAST) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt >= GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ready is suppressed while reset is held so nothing is handed off
    // during reset even though the state already reads IDLE
    assign a_ready = accept && gnt[0] && reset;
    assign b_ready = accept && gnt[1] && reset;

    // State, counter and timeout pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            tx_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            tx_err <= err_nxt;
        end
    end

    // Capture the granted byte and owner; held until the next accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data  <= 8'h00;
            grant_id <= GNT_A;
            last_gnt <= GNT_B;
        end else if (accept) begin
            tx_data  <= gnt[1] ? b_data : a_data;
            grant_id <= gnt[1];
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYC, default 4, meaning idle clk cycles inserted after each frame before the next grant.
REQ-002 Parameter BUSY_TO, default 8, meaning max clk cycles to wait for tx_busy to rise after tx_start.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 a_valid  input  1  requester A (CPU store path) has a byte.
REQ-006 a_data  input  8  requester A byte.
REQ-007 a_ready  output  1  A byte accepted this cycle.
REQ-008 b_valid  input  1  requester B (receive-echo path) has a byte.
REQ-009 b_data  input  8  requester B byte.
REQ-010 b_ready  output  1  B byte accepted this cycle.
REQ-011 tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-012 tx_data  output  8  byte to transmit, stable from tx_start until the frame ends.
REQ-013 tx_busy  input  1  transmitter frame in progress, already in clk domain.
REQ-014 grant_id  output  1  owner of current/last frame, 0=A, 1=B.
REQ-015 tx_err  output  1  one-cycle pulse on BUSY_TO timeout.

Function
REQ-016 FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP; reset state IDLE.
REQ-017 IDLE: accept only when tx_busy==0 and (a_valid|b_valid); else stay IDLE.
REQ-018 Accept: a_ready/b_ready combinational, high only in IDLE for the granted requester; tx_data and grant_id load on that edge; next state LAUNCH.
REQ-019 At most one of a_ready, b_ready high in any cycle.
REQ-020 Arbitration round-robin: with both valid, grant the requester not granted last; last-grant pointer resets to B so A wins the first tie.
REQ-021 Single valid requester granted regardless of pointer; pointer updates only on accept.
REQ-022 LAUNCH: tx_start=1 for exactly one cycle; next WAIT_BUSY; latency valid-accept (cycle N) to tx_start (N+1).
REQ-023 WAIT_BUSY: on tx_busy==1 go WAIT_DONE; after BUSY_TO cycles without it, pulse tx_err and go GAP.
REQ-024 WAIT_DONE: on tx_busy==0 go GAP.
REQ-025 GAP: count GAP_CYC cycles (counter width clog2(max(GAP_CYC,BUSY_TO))+1, shared), then IDLE; GAP_CYC=0 returns to IDLE after one cycle.
REQ-026 valid deasserted before accept: no capture, no state change; data is not required stable before accept.
REQ-027 tx_data, grant_id hold value after frame until the next accept.

Reset
REQ-028 reset low asynchronously forces IDLE, counter 0, tx_start 0, tx_data 8'h00, grant_id 0, tx_err 0, pointer=B.
REQ-029 Reset mid-frame abandons the frame; no tx_start or ready may be issued while reset is low.
REQ-030 First accept possible on the first rising clk edge after reset deasserts.

Structure
REQ-031 FSM state encoding and UART map constants (TXD 0x80000018, RXD 0x8000001C, CON 0x80000020) live in shared package uart_pkg.
REQ-032 Round-robin pick in sub-module rr_arb2 (inputs req[1:0], last; output gnt[1:0]); FSM and counter in uart_tx_arbiter.

Verification
REQ-033 a_valid=1 a_data=8'h41 alone, tx_busy rises 2 cycles after tx_start, held 20 -> a_ready at N, tx_start at N+1, tx_data=8'h41, grant_id=0, next accept >= GAP_CYC cycles after tx_busy falls.
REQ-034 a_valid and b_valid both held (8'h11, 8'h22) for 4 frames -> grant order A,B,A,B; tx_data 11,22,11,22.
REQ-035 tx_busy held 0 after tx_start -> tx_err pulse exactly BUSY_TO cycles after WAIT_BUSY entry, then GAP, then IDLE.
REQ-036 tx_busy=1 in IDLE with a_valid=1 -> a_ready stays 0 until tx_busy=0.
REQ-037 reset asserted during WAIT_DONE -> outputs at reset values immediately, tx_start never pulses, first accept after release behaves as REQ-033.
